// File: rtl/fifo_write_arbiter.sv
// Burst round-robin arbiter that merges NUM_IN FWFT FIFOs into one downstream FIFO
// through a single output stage. Define FIFO_ARB_TAG_EN to prepend the source index to out_din.
module fifo_write_arbiter #(
    parameter int NUM_IN     = 4,
    parameter int DATA_WIDTH = 32,
    parameter int SEL_WIDTH  = 2,
    parameter int MAX_BURST  = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_IN-1:0]            in_empty_n,
    input  logic [NUM_IN*DATA_WIDTH-1:0] in_dout,
    output logic [NUM_IN-1:0]            in_read,
    input  logic                         out_full_n,
    output logic                         out_write,
`ifdef FIFO_ARB_TAG_EN
    output logic [DATA_WIDTH+SEL_WIDTH-1:0] out_din,
`else
    output logic [DATA_WIDTH-1:0]           out_din,
`endif
    output logic [SEL_WIDTH-1:0]         out_grant_id
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);
`ifdef FIFO_ARB_TAG_EN
    localparam int STAGE_W = DATA_WIDTH + SEL_WIDTH;
`else
    localparam int STAGE_W = DATA_WIDTH;
`endif

    typedef enum logic {
        ST_ARB,
        ST_BURST
    } state_t;

    state_t               state;
    logic [SEL_WIDTH-1:0] cur;
    logic [CNT_W-1:0]     cnt;
    logic                 stage_valid;
    logic [STAGE_W-1:0]   stage_data;

    logic                  stage_ready;
    logic                  keep;
    logic                  any_ne;
    logic                  pop;
    logic [SEL_WIDTH-1:0]  cand;
    logic [SEL_WIDTH-1:0]  scan_idx;
    logic [SEL_WIDTH-1:0]  grant_idx;
    logic [DATA_WIDTH-1:0] grant_word;

    // Rotating scan starting after the current owner; walking the offsets from
    // farthest to nearest lets the nearest nonempty input win the last assignment.
    always_comb begin
        // NOTE: defaults first so no path leaves a variable unassigned (no latch).
        scan_idx = cur;
        cand     = '0;
        for (int k = NUM_IN; k >= 1; k--) begin
            cand = SEL_WIDTH'((int'(cur) + k) % NUM_IN);
            if (in_empty_n[cand]) begin
                scan_idx = cand;
            end
        end
    end

    always_comb begin
        stage_ready = ~stage_valid | out_full_n;
        any_ne      = |in_empty_n;
        keep        = (state == ST_BURST) && in_empty_n[cur] && (cnt < CNT_W'(MAX_BURST));
        grant_idx   = keep ? cur : scan_idx;
        // Reset gates the pop combinationally so no word leaves a source while held in reset.
        pop         = stage_ready & any_ne & ~reset;
    end

    always_comb begin
        grant_word = '0;
        in_read    = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (grant_idx == SEL_WIDTH'(i)) begin
                grant_word = in_dout[i*DATA_WIDTH +: DATA_WIDTH];
                in_read[i] = pop;
            end
        end
    end

    // Arbitration state and output stage advance together, and only when the
    // stage can accept a word; backpressure therefore freezes both.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_ARB;
            cur         <= SEL_WIDTH'(NUM_IN - 1);
            cnt         <= '0;
            stage_valid <= 1'b0;
            // NOTE: the data register is reset too so out_din is defined out of reset.
            stage_data  <= '0;
        end else if (stage_ready) begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            stage_valid <= pop;
            if (pop) begin
`ifdef FIFO_ARB_TAG_EN
                stage_data <= {grant_idx, grant_word};
`else
                stage_data <= grant_word;
`endif
                if (keep) begin
                    cnt <= cnt + 1'b1;
                end else begin
                    state <= ST_BURST;
                    cur   <= grant_idx;
                    cnt   <= CNT_W'(1);
                end
            end else begin
                state <= ST_ARB;
                cnt   <= '0;
            end
        end
    end

    assign out_write    = stage_valid & out_full_n;
    assign out_din      = stage_data;
    assign out_grant_id = cur;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter: a 4-input instance with MAX_BURST=16 fed by
// modelled FWFT sources, plus a MAX_BURST=1 instance for the round-robin case.
module tb_fifo_write_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int SW = 2;
`ifdef FIFO_ARB_TAG_EN
    localparam int OW = DW + SW;
`else
    localparam int OW = DW;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [N-1:0]    in_empty_n, in_read;
    logic [N*DW-1:0] in_dout;
    logic            out_full_n, out_write;
    logic [OW-1:0]   out_din;
    logic [SW-1:0]   out_grant_id;

    logic [N-1:0]    in_empty_n1, in_read1;
    logic [N*DW-1:0] in_dout1;
    logic            out_full_n1, out_write1;
    logic [OW-1:0]   out_din1;
    logic [SW-1:0]   out_grant_id1;

    fifo_write_arbiter #(.NUM_IN(N), .DATA_WIDTH(DW), .SEL_WIDTH(SW), .MAX_BURST(16)) dut (
        .clk(clk), .reset(reset), .in_empty_n(in_empty_n), .in_dout(in_dout),
        .in_read(in_read), .out_full_n(out_full_n), .out_write(out_write),
        .out_din(out_din), .out_grant_id(out_grant_id)
    );

    fifo_write_arbiter #(.NUM_IN(N), .DATA_WIDTH(DW), .SEL_WIDTH(SW), .MAX_BURST(1)) dut1 (
        .clk(clk), .reset(reset), .in_empty_n(in_empty_n1), .in_dout(in_dout1),
        .in_read(in_read1), .out_full_n(out_full_n1), .out_write(out_write1),
        .out_din(out_din1), .out_grant_id(out_grant_id1)
    );

    logic [DW-1:0] mem [N][64];
    int            head [N];
    int            tail [N];

    int n_checks = 0;
    int n_errors = 0;

    logic [N-1:0]  s_rd, s_rd1;
    logic          s_wr, s_wr1;
    logic [OW-1:0] s_din, s_din1;
    logic [SW-1:0] s_gid;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] word(input int src, input int j);
        return {src[15:0], j[15:0]};
    endfunction

    task automatic drive_sources();
        for (int i = 0; i < N; i++) begin
            in_empty_n[i]          = (head[i] != tail[i]);
            in_dout[i*DW +: DW]    = mem[i][head[i]];
        end
    endtask

    task automatic clear_sources();
        for (int i = 0; i < N; i++) begin
            head[i] = 0;
            tail[i] = 0;
            for (int j = 0; j < 64; j++) mem[i][j] = '0;
        end
        drive_sources();
    endtask

    task automatic push(input int src, input logic [DW-1:0] d);
        mem[src][tail[src]] = d;
        tail[src]++;
        drive_sources();
    endtask

    // Samples the cycle that ends at this edge, then applies pops 1 time unit later.
    task automatic step();
        @(posedge clk);
        s_rd   = in_read;
        s_wr   = out_write;
        s_din  = out_din;
        s_gid  = out_grant_id;
        s_rd1  = in_read1;
        s_wr1  = out_write1;
        s_din1 = out_din1;
        #1;
        for (int i = 0; i < N; i++) if (s_rd[i]) head[i]++;
        drive_sources();
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        out_full_n  = 1'b1;
        in_empty_n1 = '0;
        clear_sources();
        repeat (2) step();
        reset = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        out_full_n  = 1'b1;
        out_full_n1 = 1'b1;
        in_empty_n1 = '0;
        in_dout1    = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'hA0A0_A0A0};
        clear_sources();
        push(0, 32'h1234_5678);
        #3;
        check("reset out_write", out_write, 0);
        check("reset in_read", in_read, 0);
        check("reset grant_id", out_grant_id, 3);
        check("reset out_din", out_din, 0);

        // All four inputs full: 16-word bursts 0,1,2,3,0 back to back.
        do_reset();
        for (int s = 0; s < N; s++) for (int j = 0; j < 32; j++) push(s, word(s, j));
        for (int cyc = 0; cyc <= 80; cyc++) begin
            step();
            if (cyc == 0) begin
                check("burst first read", s_rd, 4'b0001);
                check("burst first idle", s_wr, 0);
            end else begin
                int k, b, src, j;
                k   = cyc - 1;
                b   = k / 16;
                src = b % 4;
                j   = (b / 4) * 16 + k % 16;
                check("burst write", s_wr, 1);
                check("burst data", s_din[DW-1:0], word(src, j));
                check("burst grant_id", s_gid, src);
            end
        end

        // Only input 2 with five words.
        do_reset();
        for (int j = 0; j < 5; j++) push(2, word(2, j));
        for (int cyc = 0; cyc <= 6; cyc++) begin
            step();
            check("single read", s_rd, (cyc < 5) ? 4'b0100 : 4'b0000);
            check("single write", s_wr, (cyc >= 1 && cyc <= 5) ? 1 : 0);
            if (cyc >= 1 && cyc <= 5) begin
                check("single data", s_din[DW-1:0], word(2, cyc - 1));
                check("single grant_id", s_gid, 2);
`ifdef FIFO_ARB_TAG_EN
                check("single tag", s_din[OW-1:DW], 2);
`endif
            end
        end

        // Ten cycles of backpressure mid-burst.
        do_reset();
        for (int j = 0; j < 20; j++) begin
            push(0, word(0, j));
            push(1, word(1, j));
        end
        repeat (5) step();
        out_full_n = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step();
            check("stall read", s_rd, 0);
            check("stall write", s_wr, 0);
            check("stall data held", s_din[DW-1:0], word(0, 4));
        end
        out_full_n = 1'b1;
        for (int k = 0; k < 16; k++) begin
            step();
            if (k == 0) check("resume read", s_rd, 4'b0001);
            check("resume write", s_wr, 1);
            check("resume data", s_din[DW-1:0], (k < 12) ? word(0, 4 + k) : word(1, k - 12));
        end

        // Asynchronous reset with a word in the stage.
        do_reset();
        for (int j = 0; j < 10; j++) push(1, word(1, j));
        repeat (3) step();
        check("pre-reset write", out_write, 1);
        check("pre-reset grant_id", out_grant_id, 1);
        for (int j = 0; j < 5; j++) push(0, word(0, j));
        #2 reset = 1'b1;
        #1;
        check("async reset write", out_write, 0);
        check("async reset read", in_read, 0);
        check("async reset grant_id", out_grant_id, 3);
        #2 reset = 1'b0;
        #1;
        check("post-reset read", in_read, 4'b0001);
        step();
        check("post-reset first pop", s_rd, 4'b0001);
        step();
        check("post-reset write", s_wr, 1);
        check("post-reset data", s_din[DW-1:0], word(0, 0));

        // MAX_BURST=1 instance, inputs 0 and 3 always nonempty.
        do_reset();
        in_empty_n1 = 4'b1001;
        for (int cyc = 0; cyc <= 4; cyc++) begin
            step();
            check("rr read", s_rd1, (cyc % 2 == 0) ? 4'b0001 : 4'b1000);
            if (cyc >= 1) begin
                check("rr write", s_wr1, 1);
                check("rr data", s_din1[DW-1:0], ((cyc - 1) % 2 == 0) ? 32'hA0A0_A0A0 : 32'h3333_3333);
            end
        end
        in_empty_n1 = '0;

        // Single known word from input 1.
        do_reset();
        push(1, 32'hDEAD_BEEF);
        step();
        check("tagword read", s_rd, 4'b0010);
        step();
        check("tagword write", s_wr, 1);
        check("tagword data", s_din[DW-1:0], 32'hDEAD_BEEF);
`ifdef FIFO_ARB_TAG_EN
        check("tagword full", s_din, {2'd1, 32'hDEAD_BEEF});
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/fifo_write_arbiter.md
FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

Interface
REQ-001 SHALL have parameter NUM_IN, default 4, number of producer inputs (legal range 2..16).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, payload width per input.
REQ-003 SHALL have parameter SEL_WIDTH, default 2, index width, equal to ceil(log2(NUM_IN)).
REQ-004 SHALL have parameter MAX_BURST, default 16, maximum consecutive grants to one input (legal range 1..256).
REQ-005 SHALL have port clk, input, 1, the single clock; all state is updated on its rising edge.
REQ-006 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port in_empty_n, input, NUM_IN, per-input FWFT data-available flag, bit i for input i.
REQ-008 SHALL have port in_dout, input, NUM_IN*DATA_WIDTH, per-input FWFT head word, input i in bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 SHALL have port in_read, output, NUM_IN, per-input pop strobe, one-hot or zero.
REQ-010 SHALL have port out_full_n, input, 1, downstream FIFO not-full flag.
REQ-011 SHALL have port out_write, output, 1, downstream write strobe.
REQ-012 SHALL have port out_din, output, DATA_WIDTH (+SEL_WIDTH with tag, see REQ-027), downstream write data.
REQ-013 SHALL have port out_grant_id, output, SEL_WIDTH, index of the input owning the current burst.

Function
REQ-014 SHALL hold one output stage register (stage_valid, stage_data); out_write = stage_valid & out_full_n; out_din = stage_data.
REQ-015 SHALL compute stage_ready = ~stage_valid | out_full_n; input pops occur only when stage_ready is 1.
REQ-016 SHALL assert in_read[g] in a cycle iff stage_ready, in_empty_n[g], and g is the granted index; the popped word loads the stage on the same edge.
REQ-017 SHALL have latency exactly one cycle from in_read[g] to out_write carrying that word when out_full_n=1, with sustained throughput of one word per cycle.
REQ-018 SHALL implement two states: ARB (no owner) and BURST (owner cur, burst count cnt).
REQ-019 SHALL keep grant at cur while in BURST if in_empty_n[cur]=1 and cnt<MAX_BURST; otherwise SHALL grant the first nonempty input scanning cur+1, cur+2, ... modulo NUM_IN (cur included last), with the choice made in the same cycle and no bubble.
REQ-020 SHALL, on a pop that keeps owner cur, increment cnt; on a pop that switches owner to g, set cur=g and cnt=1 and enter BURST.
REQ-021 SHALL go BURST->ARB when no input is nonempty and stage_ready=1; cnt SHALL NOT change while stage_ready=0 (backpressure freezes arbitration state).
REQ-022 SHALL, with MAX_BURST=1, degrade to strict per-word round-robin.
REQ-023 SHALL hold stage_data stable and never drop or duplicate a word while out_full_n=0; the pop and drain edges may coincide.
REQ-024 SHALL keep out_grant_id equal to cur.

Reset
REQ-025 SHALL, on reset assertion, immediately clear stage_valid and set state=ARB, cnt=0 and cur=NUM_IN-1 (so input 0 has first priority), driving out_write=0, in_read=0 and out_grant_id=NUM_IN-1; out_din is don't-care but SHALL reset to 0.
REQ-026 SHALL discard a word held in the stage when reset asserts mid-burst; after reset release, the first grant follows REQ-019 from cur=NUM_IN-1.

Configuration
REQ-027 SHALL, when macro FIFO_ARB_TAG_EN is defined, make out_din DATA_WIDTH+SEL_WIDTH wide, with {source index, data} captured alongside the word.
REQ-028 SHALL, when FIFO_ARB_TAG_EN is undefined, make out_din exactly DATA_WIDTH wide, carrying no tag logic.

Verification
REQ-029 SHALL cover: NUM_IN=4, MAX_BURST=16, all inputs continuously nonempty, out_full_n=1 -> 16 words from input 0, then 16 from 1, 2, 3, 0, with no idle cycle.
REQ-030 SHALL cover: only input 2 nonempty with 5 words -> in_read[2] asserted 5 cycles, out_write the 5 following cycles, in order, with out_grant_id=2.
REQ-031 SHALL cover: out_full_n=0 for 10 cycles mid-burst -> exactly one word is held, in_read=0, cnt frozen, and after release the stream resumes with no loss or duplicate.
REQ-032 SHALL cover: MAX_BURST=1, inputs 0 and 3 nonempty -> grants alternate 0,3,0,3.
REQ-033 SHALL cover: reset asserted asynchronously between edges with stage_valid=1 -> out_write=0 before the next edge and input 0 is the first grant after release.
REQ-034 SHALL cover, with FIFO_ARB_TAG_EN: word 0xDEADBEEF from input 1 -> out_din = {2'd1, 32'hDEADBEEF}.
